// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit_serializer front end of the 1011 detector.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit counter width for a word of 'width' bits (always at least 1).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Double-buffered parallel-to-serial converter: a shift register plus one holding
// register, so consecutive words leave on x with no idle bit between them.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Handshake: a word transfers on any rising edge with in_valid & in_ready.
    // in_ready only depends on the hold register being empty (and reset released).

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             xfer;
    logic             shifting;
    logic             at_last;
    logic             head;
    logic [WIDTH-1:0] shifted;

    assign in_ready = rst & ~hold_full_q;
    assign xfer     = in_valid & in_ready;
    assign shifting = (state_q == SHIFT) & en;
    assign at_last  = (cnt_q == CNT_LAST);
    assign head     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    // Idle and frozen cycles drive x low; consumers qualify with x_valid.
    assign x        = shifting & head;
    assign x_valid  = shifting;
    assign last_bit = shifting & at_last;
    assign busy     = (state_q == SHIFT) | hold_full_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!en) begin
                    if (xfer) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (at_last) begin
                    // Word boundary: refill from hold, else bypass a fresh word, else stop.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (xfer) begin
                        shift_d = in_data;
                        cnt_d   = '0;
                    end else begin
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (xfer) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share one stimulus
// stream and are checked every cycle against a queue-of-bits reference model.
module tb_bit_serializer;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic in_valid;
    logic [W-1:0] in_data;

    logic m_in_ready, m_x, m_x_valid, m_last_bit, m_busy;
    logic l_in_ready, l_x, l_x_valid, l_last_bit, l_busy;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_in_ready), .x(m_x), .x_valid(m_x_valid), .last_bit(m_last_bit), .busy(m_busy)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_in_ready), .x(l_x), .x_valid(l_x_valid), .last_bit(l_last_bit), .busy(l_busy)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // One entry per bit still to be emitted: {last-of-word, lsb-first bit, msb-first bit}.
    logic [2:0] exp_q[$];

    logic obs_xv, obs_x, obs_lx, obs_lb, obs_rdy;
    logic [3:0] hist;
    int det_hits;
    int run_len, max_run;

    task automatic check_b(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", name, got, exp);
        end
    endtask

    task automatic check_w(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) exp %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Words not yet fully emitted: 0 = idle, 1 = shifting, 2 = shifting with a word held.
    function automatic int outstanding();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][2]) n++;
        return n;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [W-1:0] d, input logic e, output logic acc);
        int   outst;
        logic exp_rdy, exp_xv;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        en       = e;
        #1;
        outst   = outstanding();
        exp_rdy = rst && (outst < 2);
        exp_xv  = rst && e && (outst > 0);
        check_b("m_in_ready", m_in_ready, exp_rdy);
        check_b("l_in_ready", l_in_ready, exp_rdy);
        check_b("m_busy", m_busy, outst > 0);
        check_b("l_busy", l_busy, outst > 0);
        check_b("m_x_valid", m_x_valid, exp_xv);
        check_b("l_x_valid", l_x_valid, exp_xv);
        if (exp_xv) begin
            check_b("m_x", m_x, exp_q[0][0]);
            check_b("l_x", l_x, exp_q[0][1]);
            check_b("m_last_bit", m_last_bit, exp_q[0][2]);
            check_b("l_last_bit", l_last_bit, exp_q[0][2]);
        end else begin
            check_b("m_x_idle", m_x, 1'b0);
            check_b("l_x_idle", l_x, 1'b0);
            check_b("m_last_idle", m_last_bit, 1'b0);
            check_b("l_last_idle", l_last_bit, 1'b0);
        end
        obs_xv  = m_x_valid;
        obs_x   = m_x;
        obs_lx  = l_x;
        obs_lb  = m_last_bit;
        obs_rdy = m_in_ready;
        hist = {hist[2:0], m_x};
        if (hist == 4'b1011) det_hits++;
        if (m_x_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        acc = v && exp_rdy;
        @(posedge clk);
        if (exp_xv) void'(exp_q.pop_front());
        if (acc) for (int i = 0; i < W; i++) exp_q.push_back({(i == W - 1), d[i], d[W-1-i]});
    endtask

    task automatic send(input logic [W-1:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 40) begin
            step(1'b1, d, 1'b1, acc);
            n++;
        end
        check_b("send_accepted", acc, 1'b1);
    endtask

    task automatic idle(input int n, input logic e);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, e, acc);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_m;   // x over time, first bit in [7], MSB-first instance
        logic [7:0] seq_l;   // same for the LSB-first instance
        int         hits;    // 1011 occurrences on the MSB-first x stream
    } vec_t;

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic [7:0] gm, gl;
        int         nv, lbpos, nlow, ninv;

        vecs[0] = '{8'hB0, 8'b10110000, 8'b00001101, 1};
        vecs[1] = '{8'h0D, 8'b00001101, 8'b10110000, 0};
        vecs[2] = '{8'hFF, 8'b11111111, 8'b11111111, 0};
        vecs[3] = '{8'h01, 8'b00000001, 8'b10000000, 0};
        vecs[4] = '{8'hA5, 8'b10100101, 8'b10100101, 0};
        vecs[5] = '{8'h3C, 8'b00111100, 8'b00111100, 0};
        vecs[6] = '{8'h96, 8'b10010110, 8'b01101001, 1};

        hist = '0; det_hits = 0; run_len = 0; max_run = 0;
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_b("rst_in_ready", m_in_ready, 1'b0);
        check_b("rst_x", m_x, 1'b0);
        check_b("rst_x_valid", m_x_valid, 1'b0);
        check_b("rst_last_bit", m_last_bit, 1'b0);
        check_b("rst_busy", m_busy, 1'b0);
        check_b("rst_l_busy", l_busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(2, 1'b1);

        // Single words, both bit orders
        for (int v = 0; v < 7; v++) begin
            hist = '0; det_hits = 0;
            send(vecs[v].data);
            gm = '0; gl = '0; nv = 0; lbpos = 0;
            for (int k = 0; k < 10; k++) begin
                step(1'b0, '0, 1'b1, acc);
                if (k == 0) check_b("vec_latency1", obs_xv, 1'b1);
                if (obs_xv) begin
                    gm = {gm[6:0], obs_x};
                    gl = {gl[6:0], obs_lx};
                    nv++;
                    if (obs_lb) lbpos = nv;
                end
            end
            check_w("vec_nvalid", nv, 8);
            check_w("vec_lastpos", lbpos, 8);
            check_w("vec_seq_msb", int'(gm), int'(vecs[v].seq_m));
            check_w("vec_seq_lsb", int'(gl), int'(vecs[v].seq_l));
            check_w("vec_det_hits", det_hits, vecs[v].hits);
        end

        // Back-to-back words with in_valid held high
        run_len = 0; max_run = 0; nlow = 0;
        step(1'b1, 8'hB5, 1'b1, acc);
        check_b("b2b_acc0", acc, 1'b1);
        step(1'b1, 8'h0B, 1'b1, acc);
        check_b("b2b_acc1", acc, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '0, 1'b1, acc);
            if (!obs_rdy) nlow++;
        end
        check_w("b2b_run", max_run, 16);
        check_w("b2b_ready_low", nlow, 7);

        // en=0 for three cycles after the third bit
        send(8'hB0);
        gm = '0; nv = 0; ninv = 0;
        for (int k = 0; k < 11; k++) begin
            step(1'b0, '0, (k < 3 || k > 5), acc);
            if (obs_xv) begin
                gm = {gm[6:0], obs_x};
                nv++;
            end else begin
                ninv++;
            end
        end
        check_w("en_gap_invalid", ninv, 3);
        check_w("en_gap_nvalid", nv, 8);
        check_w("en_gap_seq", int'(gm), int'(8'b10110000));
        idle(2, 1'b1);

        // Asynchronous reset while shifting with hold full
        send(8'hA5);
        send(8'h3C);
        idle(2, 1'b1);
        check_b("pre_rst_busy", m_busy, 1'b1);
        check_b("pre_rst_hold_full", m_in_ready, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_b("arst_x", m_x, 1'b0);
        check_b("arst_x_valid", m_x_valid, 1'b0);
        check_b("arst_last_bit", m_last_bit, 1'b0);
        check_b("arst_busy", m_busy, 1'b0);
        check_b("arst_in_ready", m_in_ready, 1'b0);
        check_b("arst_l_busy", l_busy, 1'b0);
        #10;
        rst = 1'b1;
        step(1'b0, '0, 1'b1, acc);
        check_b("post_rst_ready", obs_rdy, 1'b1);
        check_b("post_rst_xv", obs_xv, 1'b0);
        send(8'hFF);
        gm = '0; nv = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b1, acc);
            if (obs_xv) begin
                gm = {gm[6:0], obs_x};
                nv++;
            end
        end
        check_w("post_rst_nvalid", nv, 8);
        check_w("post_rst_seq", int'(gm), 255);

        // Word offered exactly on last_bit with hold empty bypasses the hold
        run_len = 0; max_run = 0;
        send(8'hC3);
        idle(7, 1'b1);
        step(1'b1, 8'h5A, 1'b1, acc);
        check_b("bypass_lastbit", obs_lb, 1'b1);
        check_b("bypass_acc", acc, 1'b1);
        idle(10, 1'b1);
        check_w("bypass_run", max_run, 16);

        // Random traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 8), acc);
        end
        idle(30, 1'b1);
        check_b("drain_busy", m_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
